fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit_pc_sel.sv | 47 ++++
 rtl/fetch_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Definitions shared by the CPU front end: instruction field positions,
//   opcode constants, next-PC select encodings, the fetch FSM state encoding
//   and the default reset PC.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Instruction word field positions (16-bit instruction format).
    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 12;
    localparam int MEMOP_MSB  = 11;
    localparam int MEMOP_LSB  = 10;

    // Major opcodes (instr[15:12]).
    localparam logic [3:0] OP_ALU    = 4'h0;
    localparam logic [3:0] OP_ALUI   = 4'h1;
    localparam logic [3:0] OP_MEM    = 4'h2;
    localparam logic [3:0] OP_BRANCH = 4'h3;
    localparam logic [3:0] OP_JAL    = 4'h4;
    localparam logic [3:0] OP_JALR   = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    // Memory sub-opcodes (instr[11:10]).
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    // Next-PC select driven by the control decoder.
    typedef enum logic [1:0] {
        PC_HALT = 2'b00,  // stop fetching
        PC_SEQ  = 2'b01,  // pc+1, or branch target when a taken branch
        PC_REG  = 2'b10,  // register-indirect target (jalr)
        PC_JMP  = 2'b11   // absolute jump target (jal)
    } pc_ctr_e;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Extract the major opcode from an instruction word.
    function automatic logic [3:0] get_opcode(input logic [15:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

    // Extract the memory sub-opcode from an instruction word.
    function automatic logic [1:0] get_mem_opcode(input logic [15:0] word);
        return word[MEMOP_MSB:MEMOP_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction memory read port between the fetch unit (master) and the
//   instruction memory (slave).
//
//   Handshake: the master raises req with a stable addr and keeps both
//   unchanged until it samples ack high on a rising clock edge; the slave
//   presents rdata in the same cycle it raises ack.  ack while req is low has
//   no meaning and is ignored by the master.
//
//   Signals:
//     req    master->slave  read request
//     addr   master->slave  word address
//     ack    slave->master  rdata valid this cycle
//     rdata  slave->master  instruction word
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_unit_pc_sel.sv
// -----------------------------------------------------------------------------
// pc_sel
//   Combinational next-PC selection for the fetch unit.
//
//   Ports:
//     pc          current PC
//     pc_ctr      next-PC select (see cpu_pkg::pc_ctr_e)
//     brch_ctr    current instruction is a conditional branch
//     brch_taken  branch condition true
//     br_target   branch destination
//     jmp_target  absolute jump destination
//     reg_target  register-indirect destination
//     next_pc     selected next PC (equals pc when halting)
//     pc_plus1    pc+1, wrapping at 2^ADDR_W
// -----------------------------------------------------------------------------
module pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_ctr,
    input  logic              brch_ctr,
    input  logic              brch_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap for free.
    assign pc_plus1 = pc + 1'b1;

    always_comb begin
        next_pc = pc;
        case (pc_ctr_e'(pc_ctr))
            // brch_taken only matters for a conditional branch on the
            // sequential path; everywhere else it is a don't-care.
            PC_SEQ:  next_pc = (brch_ctr && brch_taken) ? br_target : pc_plus1;
            PC_REG:  next_pc = reg_target;
            PC_JMP:  next_pc = jmp_target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of a simple multi-cycle CPU.  Each instruction
//   takes one FETCH phase (read from instruction memory, at least one cycle)
//   followed by one EXEC phase (instruction presented to decode, at least one
//   cycle, extended by stall).  At the end of EXEC the next PC is chosen by
//   pc_sel.  A halt request or an instruction memory timeout parks the unit
//   in HALT until reset.
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     imem            instruction memory read port (master side)
//     pc_ctr          next-PC select: 00 halt, 01 seq/branch, 10 reg, 11 jump
//     brch_ctr        current instruction is a conditional branch
//     brch_taken      branch condition true
//     br_target       branch destination
//     jmp_target      jump destination
//     reg_target      register-indirect destination
//     stall           downstream cannot accept a PC advance
//     instr_valid     instr/op_code/mem_opcode valid for decode
//     instr           instruction register
//     op_code         instr[15:12]
//     mem_opcode      instr[11:10]
//     pc              address of the instruction held in instr
//     pc_plus1        pc+1, link value for jal/jalr
//     halted          fetch stopped (halt request or timeout)
//     fetch_err       sticky instruction memory timeout flag
//     state_dbg       current FSM state, for observation
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,

    fetch_unit_if.master       imem,

    input  logic [1:0]         pc_ctr,
    input  logic               brch_ctr,
    input  logic               brch_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic [ADDR_W-1:0]  jmp_target,
    input  logic [ADDR_W-1:0]  reg_target,
    input  logic               stall,

    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op_code,
    output logic [1:0]         mem_opcode,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic               halted,
    output logic               fetch_err,
    output fetch_state_e       state_dbg
);

    // Wide enough to hold TIMEOUT itself.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  pc_inc;

    pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_sel (
        .pc         (pc_q),
        .pc_ctr     (pc_ctr),
        .brch_ctr   (brch_ctr),
        .brch_taken (brch_taken),
        .br_target  (br_target),
        .jmp_target (jmp_target),
        .reg_target (reg_target),
        .next_pc    (next_pc),
        .pc_plus1   (pc_inc)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        err_d   = err_q;

        case (state_q)
            ST_FETCH: begin
                if (imem.ack) begin
                    instr_d = imem.rdata;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle without an ack.
                    wait_d  = CNT_W'(TIMEOUT);
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end

            ST_EXEC: begin
                if (!stall) begin
                    if (pc_ctr_e'(pc_ctr) == PC_HALT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The reset state is FETCH, so the request is gated with rst_n to keep it
    // low for the whole time reset is asserted, independent of the clock.
    assign imem.req    = rst_n && (state_q == ST_FETCH);
    assign imem.addr   = pc_q;

    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
    assign fetch_err   = err_q;
    assign instr       = instr_q;
    assign op_code     = instr_q[OP_MSB:OP_LSB];
    assign mem_opcode  = instr_q[MEMOP_MSB:MEMOP_LSB];
    assign pc          = pc_q;
    assign pc_plus1    = pc_inc;
    assign state_dbg   = state_q;

endmodule
